// File: rtl/seg_scan_decoder.sv
// Seven-segment scan receiver: synchronises segment/anode lines, waits for a stable
// pattern, decodes it back to BCD and rebuilds the two-digit binary value.
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_n,
  input  logic [1:0] an_n,
  output logic [3:0] units,
  output logic [3:0] tens,
  output logic [1:0] dig_seen,
  output logic [6:0] value,
  output logic       value_valid,
  output logic       code_err
);

  typedef enum logic [1:0] {StIdle, StSettle, StCapture, StHold} state_e;

  state_e           state_q, state_d;
  logic [8:0]       sync1_q, sync2_q;
  logic [8:0]       ref_q, ref_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       units_q, units_d;
  logic [3:0]       tens_q, tens_d;
  logic [1:0]       seen_q, seen_d;
  logic [6:0]       value_q, value_d;
  logic             vv_q, vv_d;
  logic             err_q, err_d;
  logic             cap_ok_q, cap_ok_d;

  logic [8:0] smp;
  logic       an_ok;
  logic       changed;
  logic [4:0] dec;

  // Returns {legal, digit} for an active-low {a..g} pattern.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h01:   r = {1'b1, 4'd0};
      7'h4F:   r = {1'b1, 4'd1};
      7'h12:   r = {1'b1, 4'd2};
      7'h06:   r = {1'b1, 4'd3};
      7'h4C:   r = {1'b1, 4'd4};
      7'h24:   r = {1'b1, 4'd5};
      7'h20:   r = {1'b1, 4'd6};
      7'h0F:   r = {1'b1, 4'd7};
      7'h00:   r = {1'b1, 4'd8};
      7'h04:   r = {1'b1, 4'd9};
      default: r = {1'b0, 4'd0};
    endcase
    return r;
  endfunction

  assign smp     = sync2_q;
  assign an_ok   = smp[8] ^ smp[7];
  assign changed = (smp != ref_q);
  assign dec     = decode(ref_q[6:0]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ref_d    = ref_q;
    units_d  = units_q;
    tens_d   = tens_q;
    seen_d   = seen_q;
    value_d  = value_q;
    vv_d     = 1'b0;
    err_d    = 1'b0;
    cap_ok_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (an_ok) begin
          state_d = StSettle;
          cnt_d   = CNT_W'(1);
          ref_d   = smp;
        end
      end
      StSettle: begin
        if (cnt_q == CNT_W'(STABLE_CYCLES)) begin
          state_d = StCapture;
        end else if (changed) begin
          ref_d = smp;
          if (an_ok) begin
            cnt_d = CNT_W'(1);
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StCapture: begin
        state_d = StHold;
        if (dec[4]) begin
          cap_ok_d = 1'b1;
          // an_n[0] low selects the units digit
          if (!ref_q[7]) begin
            units_d   = dec[3:0];
            seen_d[0] = 1'b1;
          end else begin
            tens_d    = dec[3:0];
            seen_d[1] = 1'b1;
          end
        end else begin
          err_d = 1'b1;
        end
      end
      StHold: begin
        if (changed) begin
          ref_d = smp;
          if (an_ok) begin
            state_d = StSettle;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (cap_ok_q && (seen_q == 2'b11)) begin
      value_d = ({3'b000, tens_q} << 3) + ({3'b000, tens_q} << 1) + {3'b000, units_q};
      vv_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      sync1_q  <= '0;
      sync2_q  <= '0;
      ref_q    <= '0;
      cnt_q    <= '0;
      units_q  <= '0;
      tens_q   <= '0;
      seen_q   <= '0;
      value_q  <= '0;
      vv_q     <= 1'b0;
      err_q    <= 1'b0;
      cap_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= {an_n, seg_n};
      sync2_q  <= sync1_q;
      ref_q    <= ref_d;
      cnt_q    <= cnt_d;
      units_q  <= units_d;
      tens_q   <= tens_d;
      seen_q   <= seen_d;
      value_q  <= value_d;
      vv_q     <= vv_d;
      err_q    <= err_d;
      cap_ok_q <= cap_ok_d;
    end
  end

  assign units       = units_q;
  assign tens        = tens_q;
  assign dig_seen    = seen_q;
  assign value       = value_q;
  assign value_valid = vv_q;
  assign code_err    = err_q;

endmodule
